// File: rtl/go_screen_if.sv
// Pixel, ROM, palette and status signals for the game-over overlay.
interface go_screen_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              frame_start;
    logic              game_over;
    logic              restart;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic [ADDR_W-1:0] rom_addr;
    logic [5:0]        rom_data;
    logic [5:0]        pal_index;
    logic [3:0]        pal_red;
    logic [3:0]        pal_green;
    logic [3:0]        pal_blue;
    logic [3:0]        go_red;
    logic [3:0]        go_green;
    logic [3:0]        go_blue;
    logic              go_pixel_on;
    logic              go_active;
    logic              go_hold;
    logic              fade_done;

    // Environment side: video timing, requests, ROM and palette.
    modport master (
        output frame_start, game_over, restart, DrawX, DrawY, blank,
               rom_data, pal_red, pal_green, pal_blue,
        input  rom_addr, pal_index, go_red, go_green, go_blue,
               go_pixel_on, go_active, go_hold, fade_done
    );

    // Overlay controller side.
    modport slave (
        input  frame_start, game_over, restart, DrawX, DrawY, blank,
               rom_data, pal_red, pal_green, pal_blue,
        output rom_addr, pal_index, go_red, go_green, go_blue,
               go_pixel_on, go_active, go_hold, fade_done
    );
endinterface

// File: rtl/go_screen_ctrl.sv
// Game-over overlay: window scan, sprite ROM addressing, palette lookup and frame-timed fade.
module go_screen_ctrl #(
    parameter int unsigned IMG_W       = 240,
    parameter int unsigned IMG_H       = 80,
    parameter int unsigned X0          = 200,
    parameter int unsigned Y0          = 200,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned FADE_FRAMES = 4,
    parameter int unsigned TRANSP_IDX  = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    go_screen_if.slave  bus
);

    localparam int unsigned CNT_W   = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam int unsigned LVL_W   = 4;
    localparam logic [LVL_W-1:0] LVL_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        HOLD     = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  frm_cnt_q, frm_cnt_d;
    logic              fade_done_q, fade_done_d;
    logic              go_active_q, go_active_d;
    logic              go_hold_q, go_hold_d;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              v1_q, v1_d;
    logic              v2_q, v2_d;
    logic              go_pixel_on_q, go_pixel_on_d;
    logic [3:0]        go_red_q, go_red_d;
    logic [3:0]        go_green_q, go_green_d;
    logic [3:0]        go_blue_q, go_blue_d;

    logic [9:0]        dx_c, dy_c;
    logic              in_win_c;
    logic              step_c;
    logic [CNT_W-1:0]  cnt_adv_c;

    // Colour channel scaled by fade level; full level passes the colour untouched.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [LVL_W-1:0] lvl);
        logic [7:0] prod;
        prod = 8'(c) * 8'(lvl);
        return (lvl == LVL_MAX) ? c : prod[7:4];
    endfunction

    // S1 window test: unsigned wrap puts pixels left of / above the window out of range.
    always_comb begin
        dx_c       = bus.DrawX - 10'(X0);
        dy_c       = bus.DrawY - 10'(Y0);
        in_win_c   = (dx_c < 10'(IMG_W)) && (dy_c < 10'(IMG_H));
        rom_addr_d = in_win_c ? ADDR_W'(32'(dy_c) * IMG_W + 32'(dx_c)) : '0;
        v1_d       = in_win_c & bus.blank;
        v2_d       = v1_q;
    end

    // S3 colour stage: ownership and faded RGB, black when not owned.
    always_comb begin
        go_pixel_on_d = v2_q && (bus.rom_data != 6'(TRANSP_IDX)) &&
                        (level_q != '0) && (state_q != IDLE);
        go_red_d      = go_pixel_on_d ? scale(bus.pal_red,   level_q) : 4'd0;
        go_green_d    = go_pixel_on_d ? scale(bus.pal_green, level_q) : 4'd0;
        go_blue_d     = go_pixel_on_d ? scale(bus.pal_blue,  level_q) : 4'd0;
    end

    // Fade FSM next state; requests take priority over a coincident fade step.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        frm_cnt_d   = frm_cnt_q;
        fade_done_d = 1'b0;
        step_c      = bus.frame_start && (frm_cnt_q == CNT_W'(FADE_FRAMES - 1));
        cnt_adv_c   = !bus.frame_start ? frm_cnt_q :
                      (step_c ? '0 : frm_cnt_q + CNT_W'(1));
        case (state_q)
            IDLE: begin
                if (bus.game_over) begin
                    state_d   = FADE_IN;
                    level_d   = '0;
                    frm_cnt_d = '0;
                end
            end
            FADE_IN: begin
                if (bus.restart && !bus.game_over) begin
                    state_d   = FADE_OUT;
                    frm_cnt_d = '0;
                end else begin
                    frm_cnt_d = cnt_adv_c;
                    if (step_c) begin
                        if (level_q != LVL_MAX) level_d = level_q + LVL_W'(1);
                        if (level_q >= LVL_MAX - LVL_W'(1)) begin
                            state_d   = HOLD;
                            frm_cnt_d = '0;
                        end
                    end
                end
            end
            HOLD: begin
                level_d = LVL_MAX;
                if (bus.restart && !bus.game_over) begin
                    state_d   = FADE_OUT;
                    frm_cnt_d = '0;
                end
            end
            FADE_OUT: begin
                if (bus.game_over) begin
                    state_d   = FADE_IN;
                    frm_cnt_d = '0;
                end else begin
                    frm_cnt_d = cnt_adv_c;
                    if (step_c) begin
                        if (level_q != '0) level_d = level_q - LVL_W'(1);
                        if (level_q <= LVL_W'(1)) begin
                            state_d     = IDLE;
                            frm_cnt_d   = '0;
                            fade_done_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                level_d   = '0;
                frm_cnt_d = '0;
            end
        endcase
        go_active_d = (state_d != IDLE);
        go_hold_d   = (state_d == HOLD);
    end

    // FSM, fade and status registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            level_q     <= '0;
            frm_cnt_q   <= '0;
            fade_done_q <= 1'b0;
            go_active_q <= 1'b0;
            go_hold_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            frm_cnt_q   <= frm_cnt_d;
            fade_done_q <= fade_done_d;
            go_active_q <= go_active_d;
            go_hold_q   <= go_hold_d;
        end
    end

    // Pixel pipeline registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_q    <= '0;
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            go_pixel_on_q <= 1'b0;
            go_red_q      <= 4'd0;
            go_green_q    <= 4'd0;
            go_blue_q     <= 4'd0;
        end else begin
            rom_addr_q    <= rom_addr_d;
            v1_q          <= v1_d;
            v2_q          <= v2_d;
            go_pixel_on_q <= go_pixel_on_d;
            go_red_q      <= go_red_d;
            go_green_q    <= go_green_d;
            go_blue_q     <= go_blue_d;
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.pal_index   = bus.rom_data;
    assign bus.go_red      = go_red_q;
    assign bus.go_green    = go_green_q;
    assign bus.go_blue     = go_blue_q;
    assign bus.go_pixel_on = go_pixel_on_q;
    assign bus.go_active   = go_active_q;
    assign bus.go_hold     = go_hold_q;
    assign bus.fade_done   = fade_done_q;

endmodule

// File: tb/tb_go_screen_ctrl.sv
// Bench for go_screen_ctrl: ROM/palette models, fade reference model, directed and random steps.
module tb_go_screen_ctrl;

    localparam int IMG_W = 240;
    localparam int IMG_H = 80;
    localparam int X0    = 200;
    localparam int Y0    = 200;
    localparam int NFR   = 4;
    localparam int TRANSP = 0;

    localparam int M_IDLE = 0;
    localparam int M_IN   = 1;
    localparam int M_HOLD = 2;
    localparam int M_OUT  = 3;

    logic clk;
    logic rst;

    go_screen_if #(.ADDR_W(15)) bus ();

    go_screen_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0), .ADDR_W(15),
        .FADE_FRAMES(NFR), .TRANSP_IDX(TRANSP)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    logic [5:0] rom_mem [IMG_W*IMG_H];
    logic [3:0] pal_r [64];
    logic [3:0] pal_g [64];
    logic [3:0] pal_b [64];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int seen_done = 0;

    int m_mode  = M_IDLE;
    int m_level = 0;
    int m_cnt   = 0;
    int m_done  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous sprite ROM, one cycle of latency.
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    // Combinational palette.
    always_comb begin
        bus.pal_red   = pal_r[bus.pal_index];
        bus.pal_green = pal_g[bus.pal_index];
        bus.pal_blue  = pal_b[bus.pal_index];
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge, written as fade rules.
    task automatic model_tick(input logic fs, input logic go, input logic rs);
        m_done = 0;
        if (m_mode == M_IDLE) begin
            if (go) begin m_mode = M_IN; m_level = 0; m_cnt = 0; end
        end else if (go && m_mode == M_OUT) begin
            m_mode = M_IN; m_cnt = 0;
        end else if (rs && !go && (m_mode == M_IN || m_mode == M_HOLD)) begin
            m_mode = M_OUT; m_cnt = 0;
        end else if (fs && (m_mode == M_IN || m_mode == M_OUT)) begin
            m_cnt = (m_cnt + 1) % NFR;
            if (m_cnt == 0) begin
                if (m_mode == M_IN) begin
                    m_level = (m_level < 15) ? m_level + 1 : 15;
                    if (m_level == 15) m_mode = M_HOLD;
                end else begin
                    m_level = (m_level > 0) ? m_level - 1 : 0;
                    if (m_level == 0) begin m_mode = M_IDLE; m_done = 1; end
                end
            end
        end
    endtask

    function automatic int scl(input int c, input int lvl);
        return (lvl == 15) ? c : (c * lvl) / 16;
    endfunction

    // One clock with the given strobes, then check status against the model.
    task automatic cycle(input logic fs, input logic go, input logic rs);
        bus.frame_start = fs;
        bus.game_over   = go;
        bus.restart     = rs;
        @(posedge clk);
        model_tick(fs, go, rs);
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.game_over   = 1'b0;
        bus.restart     = 1'b0;
        if (bus.fade_done === 1'b1) seen_done++;
        chk("go_active", 32'(bus.go_active), 32'(m_mode != M_IDLE));
        chk("go_hold",   32'(bus.go_hold),   32'(m_mode == M_HOLD));
        chk("fade_done", 32'(bus.fade_done), 32'(m_done));
        chk("level",     32'(dut.level_q),   32'(m_level));
    endtask

    // Present one pixel for a cycle and check address and faded colour downstream.
    task automatic pix(input int x, input int y, input logic b);
        int dx, dy, ea, idx, on;
        dx  = x - X0;
        dy  = y - Y0;
        ea  = (dx >= 0 && dx < IMG_W && dy >= 0 && dy < IMG_H) ? dy * IMG_W + dx : 0;
        idx = int'(rom_mem[ea]);
        on  = (ea != 0 || (dx == 0 && dy == 0)) && b && idx != TRANSP &&
              m_level != 0 && m_mode != M_IDLE;
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.blank = b;
        @(posedge clk); @(negedge clk);
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        bus.blank = 1'b0;
        chk("rom_addr", 32'(bus.rom_addr), 32'(ea));
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("pixel_on", 32'(bus.go_pixel_on), 32'(on));
        chk("go_red",   32'(bus.go_red),   32'(on ? scl(int'(pal_r[idx]), m_level) : 0));
        chk("go_green", 32'(bus.go_green), 32'(on ? scl(int'(pal_g[idx]), m_level) : 0));
        chk("go_blue",  32'(bus.go_blue),  32'(on ? scl(int'(pal_b[idx]), m_level) : 0));
        @(posedge clk); @(negedge clk);
        chk("pixel_off_after", 32'(bus.go_pixel_on), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.game_over   = 1'b0;
        bus.restart     = 1'b0;
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        bus.blank = 1'b0;
        for (int i = 0; i < IMG_W * IMG_H; i++) rom_mem[i] = 6'($urandom_range(0, 63));
        for (int i = 0; i < 64; i++) begin
            pal_r[i] = 4'($urandom_range(0, 15));
            pal_g[i] = 4'($urandom_range(0, 15));
            pal_b[i] = 4'($urandom_range(0, 15));
        end

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_active",   32'(bus.go_active),   32'd0);
        chk("rst_pixel_on", 32'(bus.go_pixel_on), 32'd0);
        chk("rst_red",      32'(bus.go_red),      32'd0);
        chk("rst_addr",     32'(bus.rom_addr),    32'd0);
        chk("rst_done",     32'(bus.fade_done),   32'd0);
        chk("rst_level",    32'(dut.level_q),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fade in over 60 strobes with a pixel probe at level 8.
        cycle(1'b0, 1'b1, 1'b0);
        for (int s = 1; s <= 60; s++) begin
            repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0);
            if (s == 59) chk("lvl_after_59", 32'(dut.level_q), 32'd14);
            if (s == 60) begin
                chk("lvl_after_60",  32'(dut.level_q), 32'd15);
                chk("hold_after_60", 32'(bus.go_hold), 32'd1);
            end
            if (s == 32) begin
                rom_mem[0] = 6'd17;
                pal_r[17] = 4'hF; pal_g[17] = 4'hE; pal_b[17] = 4'h0;
                pix(200, 200, 1'b1);
                chk("lvl8_red", 32'(bus.go_red), 32'd0);
                for (int k = 0; k < 6; k++)
                    pix($urandom_range(X0, X0 + IMG_W - 1), $urandom_range(Y0, Y0 + IMG_H - 1), 1'b1);
            end
        end

        // Window edges, transparency and blanking in HOLD.
        rom_mem[19199] = 6'd33;
        pal_r[33] = 4'h5; pal_g[33] = 4'hA; pal_b[33] = 4'h3;
        rom_mem[100] = 6'(TRANSP);
        pix(439, 279, 1'b1);
        pix(440, 279, 1'b1);
        pix(199, 200, 1'b1);
        pix(200, 199, 1'b1);
        pix(200, 280, 1'b1);
        pix(300, 200, 1'b1);
        pix(300, 250, 1'b0);
        for (int k = 0; k < 16; k++)
            pix($urandom_range(180, 460), $urandom_range(180, 300), 1'($urandom_range(0, 1)));
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);

        // Reset asserted mid-HOLD while the overlay owns the pixel.
        bus.DrawX = 10'd439; bus.DrawY = 10'd279; bus.blank = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_on", 32'(bus.go_pixel_on), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_red",    32'(bus.go_red),      32'd0);
        chk("midrst_green",  32'(bus.go_green),    32'd0);
        chk("midrst_blue",   32'(bus.go_blue),     32'd0);
        chk("midrst_active", 32'(bus.go_active),   32'd0);
        chk("midrst_on",     32'(bus.go_pixel_on), 32'd0);
        m_mode = M_IDLE; m_level = 0; m_cnt = 0; m_done = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.blank = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);

        // Restart at level 10 during FADE_IN, then fade out fully.
        cycle(1'b0, 1'b1, 1'b0);
        for (int s = 0; s < 40; s++) cycle(1'b1, 1'b0, 1'b0);
        chk("lvl10", 32'(dut.level_q), 32'd10);
        cycle(1'b0, 1'b0, 1'b1);
        seen_done = 0;
        for (int s = 0; s < 40; s++) begin
            repeat ($urandom_range(0, 1)) cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0);
        end
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        chk("done_pulses", 32'(seen_done), 32'd1);
        chk("out_idle",    32'(bus.go_active), 32'd0);

        // game_over and restart together during FADE_OUT at level 5.
        cycle(1'b0, 1'b1, 1'b0);
        for (int s = 0; s < 20; s++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        seen_done = 0;
        cycle(1'b0, 1'b1, 1'b1);
        chk("both_cnt",  32'(dut.frm_cnt_q), 32'd0);
        chk("both_lvl",  32'(dut.level_q),   32'd5);
        chk("both_done", 32'(seen_done),     32'd0);
        // Restart coinciding with a fade step: step is discarded.
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        chk("coinc_lvl", 32'(dut.level_q), 32'd5);

        // Random request/strobe mix against the model.
        for (int c = 0; c < 400; c++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 29) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/go_screen_ctrl.md
Name: go_screen_ctrl

Overview:
Sequences the game-over overlay. Scans the current VGA pixel against a fixed on-screen window and generates the game-over sprite ROM address. It feeds the returned 6-bit colour index to the game-over palette and emits the palette RGB scaled by a frame-timed fade level. The VGA colour mux sits downstream and selects this block's RGB when go_pixel_on is asserted.

Parameters:
IMG_W, 240, sprite width in pixels
IMG_H, 80, sprite height in pixels
X0, 200, left screen column of the sprite window
Y0, 200, top screen row of the sprite window
ADDR_W, 15, sprite ROM address width (IMG_W*IMG_H must be at most 2^ADDR_W)
FADE_FRAMES, 4, number of frame_start strobes per fade step
TRANSP_IDX, 0, palette index treated as transparent

Ports:
Clk  in  1  system/pixel clock
Reset  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle strobe once per frame (start of vblank)
game_over  in  1  one-cycle request to show the overlay
restart  in  1  one-cycle request to dismiss the overlay
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  1 = active video
rom_addr  out  ADDR_W  sprite ROM address (synchronous ROM, 1-cycle read latency)
rom_data  in  6  colour index returned by the ROM
pal_index  out  6  index driven to the palette (combinational palette)
pal_red, pal_green, pal_blue  in  4 each  palette outputs
go_red, go_green, go_blue  out  4 each  faded RGB
go_pixel_on  out  1  overlay owns this pixel
go_active  out  1  state is not IDLE
go_hold  out  1  state is HOLD
fade_done  out  1  one-cycle pulse when FADE_OUT reaches level 0

Behaviour:
- Reset (asynchronous) values: state=IDLE, level=0, frame counter=0, rom_addr=0, go_red/go_green/go_blue=0, go_pixel_on=0, fade_done=0, all pipeline valid bits=0.
- Pipeline, 3 cycles from DrawX/DrawY to the RGB outputs:
  - S1 (registered): compute in_win = (DrawX-X0 < IMG_W) && (DrawY-Y0 < IMG_H), using unsigned subtraction so coordinates left of or above the window fall outside. rom_addr <= (DrawY-Y0)*IMG_W + (DrawX-X0) when in_win, else 0. Register v1 = in_win & blank.
  - S2: rom_data is valid. pal_index = rom_data (combinational pass-through). Register v2 <= v1.
  - S3 (registered): register c = pal_* scaled by level. go_pixel_on <= v2 & (rom_data != TRANSP_IDX) & (level != 0) & (state != IDLE).
  - When go_pixel_on=0, go_red/go_green/go_blue are 0.
- Scaling: for level 15, out = c. For level 0-14, out = (c*level)>>4, computed with an 8-bit product, upper 4 bits kept.
- Frame counter:
  - Increments on frame_start only while in FADE_IN or FADE_OUT.
  - On reaching FADE_FRAMES-1, it wraps to 0 and the level steps by one.
  - Clears to 0 on every state transition.
- State machine:
  - IDLE: game_over goes to FADE_IN with level=0.
  - FADE_IN: level increments by 1 per step. Entering level 15 goes to HOLD. restart goes to FADE_OUT, keeping the current level.
  - HOLD: level stays 15. restart goes to FADE_OUT. game_over is ignored.
  - FADE_OUT: level decrements by 1 per step. Reaching level 0 goes to IDLE and pulses fade_done for 1 cycle. game_over goes to FADE_IN, keeping the current level.
- Simultaneous events:
  - game_over and restart in the same cycle: game_over wins.
  - A request arriving in the same cycle as a fade step: the transition applies and the step is discarded.
  - Level saturates at 0 and 15 and never wraps.
- Reset mid-fade: returns immediately to IDLE; fade_done is not pulsed.

Test Plan:
- Reset asserted mid-HOLD -> same cycle: go_red/go_green/go_blue=0, go_active=0, go_pixel_on=0; after release, state is IDLE and level is 0.
- game_over pulse, then 60 frame_start strobes (FADE_FRAMES=4) -> level reaches 15 on strobe 60, go_hold=1. After strobe 59, level=14.
- Level 8 with the palette returning {F,E,0} at DrawX=200, DrawY=200, blank=1 -> rom_addr=0 one cycle later; go_red=7, go_green=7, go_blue=0, go_pixel_on=1 three cycles after the pixel is presented.
- Window edges in HOLD:
  - DrawX=439, DrawY=279 -> rom_addr=19199, go_pixel_on=1.
  - DrawX=440 or DrawX=199 -> go_pixel_on=0.
  - rom_data=TRANSP_IDX -> go_pixel_on=0.
  - blank=0 -> go_pixel_on=0.
- restart at level 10 during FADE_IN -> FADE_OUT; after 40 strobes level=0, fade_done pulses once, go_active=0.
- game_over and restart in the same cycle during FADE_OUT at level 5 -> FADE_IN at level 5, frame counter=0, no fade_done.
